// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_pkg                                                       |
// | Purpose  : Shared types, constants and address-field helpers for the       |
// |            data-cache lookup, refill and way-routing stages.               |
// | Contents : state_t       refill FSM state encoding                         |
// |            c_byte_bits   byte-offset width inside a word                   |
// |            c_tag_width   tag width for the default 32b/16-set/4-word cache |
// |            addr_*        field extraction on a zero-extended address       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_byte_bits = 2;
  localparam int c_tag_width = 32 - 4 - 2 - c_byte_bits;

  // Helpers work on a 64-bit zero-extended address so every stage can share
  // them regardless of its own ADDR_WIDTH; callers size-cast the result.
  localparam int c_max_aw = 64;

  function automatic logic [c_max_aw-1:0] field_mask(input int width);
    return (c_max_aw'(1) << width) - c_max_aw'(1);
  endfunction

  function automatic logic [c_max_aw-1:0] addr_word(input logic [c_max_aw-1:0] addr,
                                                    input int word_bits);
    return (addr >> c_byte_bits) & field_mask(word_bits);
  endfunction

  function automatic logic [c_max_aw-1:0] addr_set(input logic [c_max_aw-1:0] addr,
                                                   input int set_bits,
                                                   input int word_bits);
    return (addr >> (word_bits + c_byte_bits)) & field_mask(set_bits);
  endfunction

  function automatic logic [c_max_aw-1:0] addr_tag(input logic [c_max_aw-1:0] addr,
                                                   input int set_bits,
                                                   input int word_bits);
    return addr >> (set_bits + word_bits + c_byte_bits);
  endfunction

  function automatic logic [c_max_aw-1:0] line_base(input logic [c_max_aw-1:0] addr,
                                                    input int word_bits);
    return addr & ~field_mask(word_bits + c_byte_bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_refill_ctrl_if                                            |
// | Purpose  : Bundles the lookup, memory and fill-demux signals of the refill |
// |            controller.                                                     |
// | Modports : master  refill controller side (drives mem_*_o, fill_*_o, ...)  |
// |            slave   cache/memory environment side                           |
// | Signals  : lookup  miss_i hit_i hit_way_i addr_i valid0_i valid1_i         |
// |            memory  mem_req_o mem_addr_o mem_valid_i mem_rdata_i            |
// |            fill    fill_data_o fill_way_o fill_set_o fill_word_o fill_we_o |
// |            tag     tag_we_o tag_o                                          |
// |            status  stall_o refill_done_o                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cache_refill_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_BITS   = 4,
  parameter int WORD_BITS  = 2
);
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - WORD_BITS - 2;

  logic                  miss_i;
  logic                  hit_i;
  logic                  hit_way_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  valid0_i;
  logic                  valid1_i;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_valid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [DATA_WIDTH-1:0] fill_data_o;
  logic                  fill_way_o;
  logic [SET_BITS-1:0]   fill_set_o;
  logic [WORD_BITS-1:0]  fill_word_o;
  logic                  fill_we_o;
  logic                  tag_we_o;
  logic [TAG_W-1:0]      tag_o;
  logic                  stall_o;
  logic                  refill_done_o;

  modport master (
    input  miss_i, hit_i, hit_way_i, addr_i, valid0_i, valid1_i,
    input  mem_valid_i, mem_rdata_i,
    output mem_req_o, mem_addr_o,
    output fill_data_o, fill_way_o, fill_set_o, fill_word_o, fill_we_o,
    output tag_we_o, tag_o, stall_o, refill_done_o
  );

  modport slave (
    output miss_i, hit_i, hit_way_i, addr_i, valid0_i, valid1_i,
    output mem_valid_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o,
    input  fill_data_o, fill_way_o, fill_set_o, fill_word_o, fill_we_o,
    input  tag_we_o, tag_o, stall_o, refill_done_o
  );

endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl_lru_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lru_table                                                       |
// | Purpose  : One LRU bit per set (value = least-recently-used way).          |
// | Ports    : clk, rst_n        clock, asynchronous active-low clear          |
// |            wr_en/wr_set/wr_bit  single write port                          |
// |            rd_set -> rd_bit     combinational read                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module lru_table #(
  parameter int SET_BITS = 4
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                wr_en,
  input  wire logic [SET_BITS-1:0] wr_set,
  input  wire logic                wr_bit,
  input  wire logic [SET_BITS-1:0] rd_set,
  output logic                     rd_bit
);
  localparam int c_sets = 1 << SET_BITS;

  logic [c_sets-1:0] r_lru;

  for (genvar i = 0; i < c_sets; i++) begin : g_set
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lru[i] <= 1'b0;
      end else if (wr_en && (wr_set == SET_BITS'(i))) begin
        r_lru[i] <= wr_bit;
      end
    end
  end

  assign rd_bit = r_lru[rd_set];

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_refill_ctrl                                               |
// | Purpose  : Miss handler for the 2-way set-associative write-through data   |
// |            cache: picks a victim, streams the line from memory into the    |
// |            way demux, installs the tag and maintains per-set LRU.          |
// | Ports    : clk    rising-edge clock                                        |
// |            rst_n  asynchronous active-low reset                            |
// |            bus    cache_refill_ctrl_if.master (lookup, memory, fill, tag,  |
// |                   stall and completion signals)                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_BITS   = 4,
  parameter int WORD_BITS  = 2
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  cache_refill_ctrl_if.master bus
);
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - WORD_BITS - c_byte_bits;
  localparam logic [WORD_BITS-1:0] c_last_word = '1;

  state_t r_state, w_next;

  logic [SET_BITS-1:0]   r_set;
  logic [TAG_W-1:0]      r_tag;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_victim;
  logic [WORD_BITS-1:0]  r_cnt;

  logic [c_max_aw-1:0]   w_addr_ext;
  logic [SET_BITS-1:0]   w_lookup_set;
  logic [TAG_W-1:0]      w_lookup_tag;
  logic [ADDR_WIDTH-1:0] w_lookup_base;
  logic                  w_lru_rd;
  logic                  w_victim;

  logic                  w_lru_we;
  logic [SET_BITS-1:0]   w_lru_set;
  logic                  w_lru_bit;

  logic                  w_mem_req;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_fill_data;
  logic                  w_fill_way;
  logic [SET_BITS-1:0]   w_fill_set;
  logic [WORD_BITS-1:0]  w_fill_word;
  logic                  w_fill_we;
  logic                  w_tag_we;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_stall;
  logic                  w_done;

  assign w_addr_ext    = c_max_aw'(bus.addr_i);
  assign w_lookup_set  = SET_BITS'(addr_set(w_addr_ext, SET_BITS, WORD_BITS));
  assign w_lookup_tag  = TAG_W'(addr_tag(w_addr_ext, SET_BITS, WORD_BITS));
  assign w_lookup_base = ADDR_WIDTH'(line_base(w_addr_ext, WORD_BITS));

  // An invalid way is always preferred so cold sets fill without evicting.
  assign w_victim = !bus.valid0_i ? 1'b0 :
                    !bus.valid1_i ? 1'b1 : w_lru_rd;

  lru_table #(
    .SET_BITS (SET_BITS)
  ) u_lru (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (w_lru_we),
    .wr_set (w_lru_set),
    .wr_bit (w_lru_bit),
    .rd_set (w_lookup_set),
    .rd_bit (w_lru_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_set    <= '0;
      r_tag    <= '0;
      r_base   <= '0;
      r_victim <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && bus.miss_i) begin
        r_set    <= w_lookup_set;
        r_tag    <= w_lookup_tag;
        r_base   <= w_lookup_base;
        r_victim <= w_victim;
        r_cnt    <= '0;
      end else if ((r_state == FILL) && bus.mem_valid_i) begin
        // Wraps to 0 on the last beat, ready for the next refill.
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_lru_we    = 1'b0;
    w_lru_set   = w_lookup_set;
    w_lru_bit   = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_addr  = '0;
    w_fill_data = '0;
    w_fill_way  = 1'b0;
    w_fill_set  = '0;
    w_fill_word = '0;
    w_fill_we   = 1'b0;
    w_tag_we    = 1'b0;
    w_tag       = '0;
    w_stall     = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      IDLE: begin
        w_stall = bus.miss_i;
        if (bus.miss_i) begin
          // A simultaneous hit is ignored: the refill owns the LRU update.
          w_next = FILL;
        end else if (bus.hit_i) begin
          w_lru_we  = 1'b1;
          w_lru_bit = ~bus.hit_way_i;
        end
      end

      FILL: begin
        w_stall    = 1'b1;
        w_mem_req  = 1'b1;
        w_mem_addr = r_base + ADDR_WIDTH'({r_cnt, {c_byte_bits{1'b0}}});
        w_fill_way = r_victim;
        w_fill_set = r_set;
        if (bus.mem_valid_i) begin
          w_fill_we   = 1'b1;
          w_fill_data = bus.mem_rdata_i;
          w_fill_word = r_cnt;
          if (r_cnt == c_last_word) begin
            w_next = DONE;
          end
        end
      end

      DONE: begin
        w_stall    = 1'b1;
        w_fill_way = r_victim;
        w_fill_set = r_set;
        w_tag_we   = 1'b1;
        w_tag      = r_tag;
        w_done     = 1'b1;
        w_lru_we   = 1'b1;
        w_lru_set  = r_set;
        w_lru_bit  = ~r_victim;
        w_next     = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign bus.mem_req_o     = w_mem_req;
  assign bus.mem_addr_o    = w_mem_addr;
  assign bus.fill_data_o   = w_fill_data;
  assign bus.fill_way_o    = w_fill_way;
  assign bus.fill_set_o    = w_fill_set;
  assign bus.fill_word_o   = w_fill_word;
  assign bus.fill_we_o     = w_fill_we;
  assign bus.tag_we_o      = w_tag_we;
  assign bus.tag_o         = w_tag;
  assign bus.stall_o       = w_stall;
  assign bus.refill_done_o = w_done;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_refill_ctrl                                            |
// | Purpose  : Directed scoreboard bench for cache_refill_ctrl. Expected fill  |
// |            writes and tag installs are queued as each miss is issued and   |
// |            a monitor pops them whenever the DUT strobes fill_we/tag_we.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cache_refill_ctrl;

  logic clk;
  logic rst_n;

  cache_refill_ctrl_if #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .SET_BITS   (4),
    .WORD_BITS  (2)
  ) bus ();

  cache_refill_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .SET_BITS   (4),
    .WORD_BITS  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        way;
    logic [3:0]  set;
    logic [1:0]  word;
    logic [31:0] data;
    logic [31:0] addr;
  } fill_t;

  typedef struct {
    logic        way;
    logic [3:0]  set;
    logic [23:0] tag;
  } tag_t;

  fill_t exp_fill[$];
  tag_t  exp_tag[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] addr, input int w);
    return {addr[15:0], 16'hBE00 + 16'(w)};
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin : mon
    fill_t f;
    tag_t  t;
    if (rst_n) begin
      if (bus.fill_we_o) begin
        n_writes++;
        if (exp_fill.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fill_unexpected: write word %0d data 0x%0h, none expected",
                   bus.fill_word_o, bus.fill_data_o);
        end else begin
          f = exp_fill.pop_front();
          chk("fill_data", bus.fill_data_o, f.data);
          chk("fill_word", bus.fill_word_o, f.word);
          chk("fill_way",  bus.fill_way_o,  f.way);
          chk("fill_set",  bus.fill_set_o,  f.set);
          chk("mem_addr",  bus.mem_addr_o,  f.addr);
        end
      end
      if (bus.tag_we_o) begin
        if (exp_tag.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tag_unexpected: tag 0x%0h installed, none expected", bus.tag_o);
        end else begin
          t = exp_tag.pop_front();
          chk("tag_value", bus.tag_o,      t.tag);
          chk("tag_set",   bus.fill_set_o, t.set);
          chk("tag_way",   bus.fill_way_o, t.way);
        end
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_mem_req"},   bus.mem_req_o,     0);
    chk({name, "_mem_addr"},  bus.mem_addr_o,    0);
    chk({name, "_fill_data"}, bus.fill_data_o,   0);
    chk({name, "_fill_way"},  bus.fill_way_o,    0);
    chk({name, "_fill_set"},  bus.fill_set_o,    0);
    chk({name, "_fill_word"}, bus.fill_word_o,   0);
    chk({name, "_fill_we"},   bus.fill_we_o,     0);
    chk({name, "_tag_we"},    bus.tag_we_o,      0);
    chk({name, "_tag"},       bus.tag_o,         0);
    chk({name, "_stall"},     bus.stall_o,       0);
    chk({name, "_done"},      bus.refill_done_o, 0);
  endtask

  // Issue one miss and feed beats following pat (bit i = mem_valid in fill
  // cycle i, 1 beyond plen). abort_after >= 0 stops after that many beats
  // without finishing the line, leaving the caller mid-fill.
  task automatic run_miss(input logic [31:0] addr, input logic v0, input logic v1,
                          input logic hit, input logic hw, input logic exp_way,
                          input logic [15:0] pat, input int plen, input int abort_after);
    int nbeats;
    int beats;
    int cyc;
    logic mv;
    logic [31:0] base;
    fill_t f;
    tag_t  t;
    base   = {addr[31:4], 4'h0};
    nbeats = (abort_after < 0) ? 4 : abort_after;
    for (int w = 0; w < nbeats; w++) begin
      f.way  = exp_way;
      f.set  = addr[7:4];
      f.word = 2'(w);
      f.data = beat_data(addr, w);
      f.addr = base + 32'(4 * w);
      exp_fill.push_back(f);
    end
    if (abort_after < 0) begin
      t.way = exp_way;
      t.set = addr[7:4];
      t.tag = addr[31:8];
      exp_tag.push_back(t);
    end
    n_writes = 0;

    @(posedge clk); #1;
    bus.miss_i    = 1'b1;
    bus.hit_i     = hit;
    bus.hit_way_i = hw;
    bus.addr_i    = addr;
    bus.valid0_i  = v0;
    bus.valid1_i  = v1;
    @(negedge clk);
    chk("stall_on_miss", bus.stall_o, 1);
    chk("no_req_in_idle", bus.mem_req_o, 0);
    @(posedge clk); #1;
    bus.miss_i = 1'b0;
    bus.hit_i  = 1'b0;

    beats = 0;
    cyc   = 0;
    while (beats < nbeats && cyc < 40) begin
      mv = (cyc < plen) ? pat[cyc] : 1'b1;
      bus.mem_valid_i = mv;
      bus.mem_rdata_i = mv ? beat_data(addr, beats) : 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stall_in_fill", bus.stall_o, 1);
      chk("req_in_fill", bus.mem_req_o, 1);
      chk("victim_way", bus.fill_way_o, exp_way);
      if (!mv) chk("no_write_idle_beat", bus.fill_we_o, 0);
      if (mv) beats++;
      cyc++;
      @(posedge clk); #1;
    end
    bus.mem_valid_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
    if (cyc >= 40) chk("beat_timeout", beats, nbeats);

    if (abort_after < 0) begin
      @(negedge clk);
      chk("refill_done", bus.refill_done_o, 1);
      chk("stall_in_done", bus.stall_o, 1);
      chk("no_req_in_done", bus.mem_req_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_released", bus.stall_o, 0);
      chk("done_one_cycle", bus.refill_done_o, 0);
      chk("write_count", n_writes, 4);
    end else begin
      chk("write_count_partial", n_writes, nbeats);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n           = 1'b0;
    bus.miss_i      = 1'b0;
    bus.hit_i       = 1'b0;
    bus.hit_way_i   = 1'b0;
    bus.addr_i      = 32'h0;
    bus.valid0_i    = 1'b0;
    bus.valid1_i    = 1'b0;
    bus.mem_valid_i = 1'b0;
    bus.mem_rdata_i = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cold miss, set 4, both ways invalid: way 0. lru[4] -> 1.
    run_miss(32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16, -1);
    // Way 0 valid, new tag: way 1. lru[4] -> 0.
    run_miss(32'h0000_1040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16, -1);

    // Hit on way 0 in set 4: lru[4] -> 1, no stall.
    @(posedge clk); #1;
    bus.hit_i     = 1'b1;
    bus.hit_way_i = 1'b0;
    bus.addr_i    = 32'h0000_1040;
    bus.valid0_i  = 1'b1;
    bus.valid1_i  = 1'b1;
    @(negedge clk);
    chk("hit_no_stall", bus.stall_o, 0);
    @(posedge clk); #1;
    bus.hit_i = 1'b0;

    // Both valid after hit on way 0: victim way 1, gappy memory 1,0,0,1,1,0,1.
    run_miss(32'h0000_2040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0059, 7, -1);
    // lru[4]=0; miss with a concurrent hit on way 0: refill to way 0.
    run_miss(32'h0000_3040, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16, -1);
    // Set 5 untouched so far: lru[5]=0 -> way 0.
    run_miss(32'h0000_0050, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16, -1);
    // lru[4]=1 -> way 1; aborted by reset after two beats.
    run_miss(32'h0000_4040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16, 2);

    bus.mem_valid_i = 1'b1;
    bus.mem_rdata_i = 32'h1234_5678;
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_no_write", bus.fill_we_o, 0);
    @(posedge clk); #1;
    bus.mem_valid_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
    rst_n = 1'b1;

    // LRU cleared by reset: way 0 again, restart at word 0. lru[4] -> 1.
    run_miss(32'h0000_4040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16, -1);
    // DONE updated lru[4] to 1: way 1.
    run_miss(32'h0000_5040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16, -1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fill_queue_drained", exp_fill.size(), 0);
    chk("tag_queue_drained", exp_tag.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
